// File: rtl/load_store_unit.sv
// load_store_unit: RV64 load/store sequencer for a doubleword-wide data memory.
// Optional saturating performance counters are enabled by defining LSU_CNT_EN.
module load_store_unit #(
   parameter int MEM_BYTES = 64,
   parameter int CNT_W     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [63:0] addr,
   input  logic [63:0] store_data,
   output logic        resp_valid,
   output logic [63:0] load_data,
   output logic        access_err,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_rdata
`ifdef LSU_CNT_EN
   ,
   output logic [CNT_W-1:0] ld_cnt,
   output logic [CNT_W-1:0] st_cnt,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LD_RD = 3'd1,
      ST_RD = 3'd2,
      ST_WR = 3'd3,
      RESP  = 3'd4
   } state_t;

   localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [63:0] addr_r;
   logic [2:0]  funct3_r;
   logic        is_load_r;
   logic [63:0] merged_r;
   logic        accept_s;
   logic        err_s;
   logic [3:0]  size_s;
   logic [5:0]  lane_shift_s;

   function automatic logic [63:0] lane_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 64'h0000_0000_0000_00FF;
         2'b01:   return 64'h0000_0000_0000_FFFF;
         2'b10:   return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{56{raw[7]}}, raw[7:0]};
         3'b001:  return {{48{raw[15]}}, raw[15:0]};
         3'b010:  return {{32{raw[31]}}, raw[31:0]};
         3'b011:  return raw;
         3'b100:  return {56'd0, raw[7:0]};
         3'b101:  return {48'd0, raw[15:0]};
         3'b110:  return {32'd0, raw[31:0]};
         default: return 64'd0;
      endcase
   endfunction

   // Request legality; the range sum is 65 bits wide so high addresses cannot wrap.
   always_comb begin
      size_s       = 4'd1 << funct3[1:0];
      lane_shift_s = {addr_r[2:0], 3'b000};
      accept_s     = req_valid & (state_r == IDLE) & (is_load | is_store);
      err_s        = (is_load & is_store)
                   | (is_load ? (funct3 == 3'b111) : funct3[2])
                   | (({1'b0, addr[2:0]} + size_s) > 4'd8)
                   | (({1'b0, addr} + {61'd0, size_s}) > MEM_LIMIT);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (!accept_s) begin
               state_nxt_s = IDLE;
            end else if (err_s) begin
               state_nxt_s = RESP;
            end else if (is_load) begin
               state_nxt_s = LD_RD;
            end else if (funct3[1:0] == 2'b11) begin
               state_nxt_s = ST_WR;
            end else begin
               state_nxt_s = ST_RD;
            end
         end
         LD_RD:   state_nxt_s = RESP;
         ST_RD:   state_nxt_s = ST_WR;
         ST_WR:   state_nxt_s = RESP;
         RESP:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand capture, load extraction and read-modify-write merge; merged_r holds raw store data until ST_RD.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r     <= 64'd0;
         funct3_r   <= 3'd0;
         is_load_r  <= 1'b0;
         merged_r   <= 64'd0;
         load_data  <= 64'd0;
         access_err <= 1'b0;
      end else if (accept_s) begin
         addr_r     <= addr;
         funct3_r   <= funct3;
         is_load_r  <= is_load;
         merged_r   <= store_data;
         load_data  <= 64'd0;
         access_err <= err_s;
      end else begin
         case (state_r)
            LD_RD: load_data <= extend(mem_rdata >> lane_shift_s, funct3_r);
            ST_RD: merged_r  <= (mem_rdata & ~(lane_mask(funct3_r[1:0]) << lane_shift_s))
                              | ((merged_r << lane_shift_s) & (lane_mask(funct3_r[1:0]) << lane_shift_s));
            RESP: begin
               load_data  <= 64'd0;
               access_err <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake and memory strobes; strobes drop immediately when reset rises.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = 64'd0;
      mem_wdata  = 64'd0;
      case (state_r)
         IDLE: req_ready = 1'b1;
         LD_RD, ST_RD: begin
            mem_read = ~reset;
            mem_addr = {addr_r[63:3], 3'b000};
         end
         ST_WR: begin
            mem_write = ~reset;
            mem_addr  = {addr_r[63:3], 3'b000};
            mem_wdata = merged_r;
         end
         RESP:    resp_valid = 1'b1;
         default: req_ready  = 1'b0;
      endcase
   end

`ifdef LSU_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Completion counters, bumped once per response.
   always_ff @(posedge clk) begin
      if (reset) begin
         ld_cnt  <= '0;
         st_cnt  <= '0;
         err_cnt <= '0;
      end else if (state_r == RESP) begin
         if (access_err) begin
            err_cnt <= sat_inc(err_cnt);
         end else if (is_load_r) begin
            ld_cnt <= sat_inc(ld_cnt);
         end else begin
            st_cnt <= sat_inc(st_cnt);
         end
      end
   end
`else
   logic unused_cnt;
   assign unused_cnt = is_load_r | (CNT_W == 0);
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table-driven vectors scored through a response queue,
// plus hand sequences for reset-in-flight, ignored requests and back-to-back traffic.
module tb_load_store_unit;
   localparam int CNT_W = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, is_load, is_store;
   logic [2:0]  funct3;
   logic [63:0] addr, store_data, load_data, mem_addr, mem_wdata, mem_rdata;
   logic        resp_valid, access_err, mem_write, mem_read;
`ifdef LSU_CNT_EN
   logic [CNT_W-1:0] ld_cnt, st_cnt, err_cnt;
`endif

   load_store_unit #(.MEM_BYTES(64), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
      .store_data(store_data), .resp_valid(resp_valid), .load_data(load_data),
      .access_err(access_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
`ifdef LSU_CNT_EN
      , .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [63:0] mem [8];
   assign mem_rdata = mem[mem_addr[5:3]];
   always @(posedge clk) if (mem_write === 1'b1) mem[mem_addr[5:3]] <= mem_wdata;

   typedef struct {
      logic ld; logic st; logic [2:0] f3; logic [63:0] a; logic [63:0] wd;
      logic err; logic [63:0] data; logic chk; int lat; int rd; int wr;
   } vec_t;
   typedef struct { logic err; logic [63:0] data; logic chk; int lat; int acc; int kind; } exp_t;

   exp_t sb_q[$];
   vec_t vecs[30];
   int   n_cmp = 0, n_bad = 0, cyc = 0, rd_cnt = 0, wr_cnt = 0, n_resp = 0;
   int   exp_ldc = 0, exp_stc = 0, exp_errc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor and strobe bookkeeping, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (mem_read === 1'b1) rd_cnt++;
      if (mem_write === 1'b1) wr_cnt++;
      check("strobe_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
      check("mem_addr_aligned", {61'd0, mem_addr[2:0]}, 64'd0);
      if (resp_valid === 1'b1) begin
         n_resp++;
         if (sb_q.size() == 0) begin
            check("unexpected_resp", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("access_err", {63'd0, access_err}, {63'd0, e.err});
            if (e.chk) check("load_data", load_data, e.data);
            check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            if (e.kind == 2) exp_errc++;
            else if (e.kind == 0) exp_ldc++;
            else exp_stc++;
         end
      end
   end

   function automatic vec_t ldv(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
      vec_t v = '{1'b1, 1'b0, f3, a, 64'd0, 1'b0, d, 1'b1, 2, 1, 0};
      return v;
   endfunction
   function automatic vec_t stv(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
      vec_t v = '{1'b0, 1'b1, f3, a, wd, 1'b0, 64'd0, 1'b0,
                  (f3 == 3'b011) ? 2 : 3, (f3 == 3'b011) ? 0 : 1, 1};
      return v;
   endfunction
   function automatic vec_t erv(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a);
      vec_t v = '{ld, st, f3, a, 64'hDEAD, 1'b1, 64'd0, 1'b1, 1, 0, 0};
      return v;
   endfunction

   // Presents a request (from a falling edge) until accepted; leaves req_valid high.
   task automatic drive_req(input vec_t v);
      logic ok = 1'b0;
      int   acc;
      exp_t e;
      req_valid = 1'b1; is_load = v.ld; is_store = v.st;
      funct3 = v.f3; addr = v.a; store_data = v.wd;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (req_ready === 1'b1) begin
            acc = cyc + 1;
            @(posedge clk);
            e = '{v.err, v.data, v.chk, v.lat, acc, v.err ? 2 : (v.ld ? 0 : 1)};
            sb_q.push_back(e);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      if (!ok) check("accept_timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0, wr0, resp0;
      for (int i = 0; i < 8; i++) mem[i] = 64'd0;
      mem[0] = 64'h08; mem[1] = 64'h06; mem[2] = 64'h01; mem[7] = 64'h8899_AABB_CCDD_EEFF;
      reset = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      funct3 = 3'd0; addr = 64'd0; store_data = 64'd0;

      vecs[0]  = ldv(3'b011, 64'd8,  64'h6);
      vecs[1]  = stv(3'b000, 64'd3,  64'h80);
      vecs[2]  = ldv(3'b000, 64'd3,  64'hFFFF_FFFF_FFFF_FF80);
      vecs[3]  = ldv(3'b100, 64'd3,  64'h80);
      vecs[4]  = erv(1'b1, 1'b0, 3'b010, 64'd6);
      vecs[5]  = erv(1'b0, 1'b1, 3'b011, 64'd64);
      vecs[6]  = ldv(3'b011, 64'd56, 64'h8899_AABB_CCDD_EEFF);
      vecs[7]  = ldv(3'b001, 64'd62, 64'hFFFF_FFFF_FFFF_8899);
      vecs[8]  = ldv(3'b101, 64'd62, 64'h8899);
      vecs[9]  = ldv(3'b010, 64'd60, 64'hFFFF_FFFF_8899_AABB);
      vecs[10] = ldv(3'b110, 64'd60, 64'h8899_AABB);
      vecs[11] = ldv(3'b000, 64'd57, 64'hFFFF_FFFF_FFFF_FFEE);
      vecs[12] = stv(3'b010, 64'd4,  64'h1234_5678_CAFE_BABE);
      vecs[13] = ldv(3'b011, 64'd0,  64'hCAFE_BABE_8000_0008);
      vecs[14] = stv(3'b001, 64'd10, 64'h7777_0000_0000_BEEF);
      vecs[15] = ldv(3'b011, 64'd8,  64'h0000_0000_BEEF_0006);
      vecs[16] = erv(1'b0, 1'b1, 3'b001, 64'd7);
      vecs[17] = erv(1'b1, 1'b0, 3'b111, 64'd0);
      vecs[18] = erv(1'b0, 1'b1, 3'b100, 64'd0);
      vecs[19] = erv(1'b1, 1'b1, 3'b011, 64'd0);
      vecs[20] = stv(3'b011, 64'd24, 64'h0123_4567_89AB_CDEF);
      vecs[21] = ldv(3'b011, 64'd24, 64'h0123_4567_89AB_CDEF);
      vecs[22] = erv(1'b1, 1'b0, 3'b011, 64'd57);
      vecs[23] = ldv(3'b000, 64'd63, 64'hFFFF_FFFF_FFFF_FF88);
      vecs[24] = erv(1'b1, 1'b0, 3'b000, 64'd64);
      vecs[25] = erv(1'b1, 1'b0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFE);
      vecs[26] = stv(3'b000, 64'd63, 64'h7F);
      vecs[27] = ldv(3'b011, 64'd56, 64'h7F99_AABB_CCDD_EEFF);
      vecs[28] = ldv(3'b110, 64'd0,  64'h8000_0008);
      vecs[29] = ldv(3'b010, 64'd0,  64'hFFFF_FFFF_8000_0008);

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_req_ready",  {63'd0, req_ready},  64'd1);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_load_data",  load_data,           64'd0);
      check("rst_access_err", {63'd0, access_err}, 64'd0);
      check("rst_mem_strobe", {62'd0, mem_read, mem_write}, 64'd0);
      check("rst_mem_addr",   mem_addr,            64'd0);
      check("rst_mem_wdata",  mem_wdata,           64'd0);

      for (int i = 0; i < 30; i++) begin
         rd0 = rd_cnt; wr0 = wr_cnt;
         drive_req(vecs[i]);
         req_valid = 1'b0;
         wait_idle();
         check($sformatf("vec%0d_rd_cycles", i), 64'(rd_cnt - rd0), 64'(vecs[i].rd));
         check($sformatf("vec%0d_wr_cycles", i), 64'(wr_cnt - wr0), 64'(vecs[i].wr));
      end

      // Request with neither load nor store set is ignored.
      rd0 = rd_cnt; wr0 = wr_cnt; resp0 = n_resp;
      req_valid = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b011; addr = 64'd8;
      repeat (4) begin
         @(negedge clk);
         check("ignored_ready", {63'd0, req_ready}, 64'd1);
      end
      req_valid = 1'b0;
      @(negedge clk);
      check("ignored_no_resp", 64'(n_resp - resp0), 64'd0);
      check("ignored_no_strobe", 64'(rd_cnt - rd0 + wr_cnt - wr0), 64'd0);

      // Reset while the sh to dword 16 is in ST_WR: write dropped, no response.
      resp0 = n_resp;
      req_valid = 1'b1; is_load = 1'b0; is_store = 1'b1; funct3 = 3'b001;
      addr = 64'd16; store_data = 64'hABCD;
      check("sh16_ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("sh16_st_rd", {63'd0, mem_read}, 64'd1);
      @(negedge clk);
      check("sh16_st_wr", {63'd0, mem_write}, 64'd1);
      reset = 1'b1;
      #1;
      check("sh16_wr_gated", {63'd0, mem_write}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_ldc = 0; exp_stc = 0; exp_errc = 0;
      check("sh16_ready_after", {63'd0, req_ready}, 64'd1);
      check("sh16_no_resp", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
      check("sh16_dword", mem[2], 64'h01);
      check("sh16_resp_count", 64'(n_resp - resp0), 64'd0);

      // Back-to-back: req_valid held high across three requests.
      resp0 = n_resp;
      drive_req(ldv(3'b011, 64'd24, 64'h0123_4567_89AB_CDEF));
      check("b2b_busy0", {63'd0, req_ready}, 64'd0);
      drive_req(stv(3'b000, 64'd25, 64'h55));
      check("b2b_busy1", {63'd0, req_ready}, 64'd0);
      drive_req(ldv(3'b100, 64'd25, 64'h55));
      req_valid = 1'b0;
      wait_idle();
      check("b2b_resp_count", 64'(n_resp - resp0), 64'd3);

      check("mem0", mem[0], 64'hCAFE_BABE_8000_0008);
      check("mem1", mem[1], 64'h0000_0000_BEEF_0006);
      check("mem2", mem[2], 64'h0000_0000_0000_0001);
      check("mem3", mem[3], 64'h0123_4567_89AB_55EF);
      check("mem4_6", mem[4] | mem[5] | mem[6], 64'd0);
      check("mem7", mem[7], 64'h7F99_AABB_CCDD_EEFF);
`ifdef LSU_CNT_EN
      check("ld_cnt",  64'(ld_cnt),  64'(exp_ldc));
      check("st_cnt",  64'(st_cnt),  64'(exp_stc));
      check("err_cnt", 64'(err_cnt), 64'(exp_errc));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
